// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, legality limits, collector states
// and the operand-need classification used by alu_operand_collector.
package alu_pkg;

  localparam int unsigned ALU_TIMEOUT_DEFAULT = 16;
  localparam int unsigned ARITH_CMD_MAX       = 10;
  localparam int unsigned LOGIC_CMD_MAX       = 13;

  typedef enum logic [3:0] {
    ARITH_ADD     = 4'd0,
    ARITH_SUB     = 4'd1,
    ARITH_ADD_CIN = 4'd2,
    ARITH_SUB_CIN = 4'd3,
    ARITH_INC_A   = 4'd4,
    ARITH_DEC_A   = 4'd5,
    ARITH_INC_B   = 4'd6,
    ARITH_DEC_B   = 4'd7,
    ARITH_CMP     = 4'd8,
    ARITH_MUL_INC = 4'd9,
    ARITH_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    LOGIC_AND    = 4'd0,
    LOGIC_NAND   = 4'd1,
    LOGIC_OR     = 4'd2,
    LOGIC_NOR    = 4'd3,
    LOGIC_XOR    = 4'd4,
    LOGIC_XNOR   = 4'd5,
    LOGIC_NOT_A  = 4'd6,
    LOGIC_NOT_B  = 4'd7,
    LOGIC_SHR1_A = 4'd8,
    LOGIC_SHL1_A = 4'd9,
    LOGIC_SHR1_B = 4'd10,
    LOGIC_SHL1_B = 4'd11,
    LOGIC_ROL    = 4'd12,
    LOGIC_ROR    = 4'd13
  } logic_cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } coll_state_e;

  function automatic logic cmd_legal(input logic mode, input int unsigned cmd);
    return mode ? (cmd <= ARITH_CMD_MAX) : (cmd <= LOGIC_CMD_MAX);
  endfunction

  // Operand mask for a legal command: bit0 = A needed, bit1 = B needed.
  function automatic logic [1:0] operand_need(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    need = 2'b11;
    if (mode) begin
      if (cmd == ARITH_INC_A || cmd == ARITH_DEC_A)
        need = 2'b01;
      else if (cmd == ARITH_INC_B || cmd == ARITH_DEC_B)
        need = 2'b10;
    end else begin
      if (cmd == LOGIC_NOT_A || cmd == LOGIC_SHR1_A || cmd == LOGIC_SHL1_A)
        need = 2'b01;
      else if (cmd == LOGIC_NOT_B || cmd == LOGIC_SHR1_B || cmd == LOGIC_SHL1_B)
        need = 2'b10;
    end
    return need;
  endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Counts WAIT edges for the operand collector; expired is registered and high
// while the coming enabled edge is the TIMEOUT-th one since clear.
module alu_wait_timer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= (TIMEOUT <= 1);
    end else if (enable) begin
      count   <= count + CW'(1);
      expired <= ((count + CW'(1)) == CW'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/alu_operand_collector.sv
// Collects ALU operands that may arrive on different cycles and issues one
// registered operation pulse. Define ALU_COLLECT_TIMEOUT_EN to bound WAIT.
module alu_operand_collector
  import alu_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned M       = 4,
  parameter int unsigned TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         mode,
  input  logic [M-1:0] cmd,
  input  logic [1:0]   inp_valid,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  input  logic         cin,
  output logic         iss_valid,
  output logic         iss_mode,
  output logic [M-1:0] iss_cmd,
  output logic [N-1:0] iss_opa,
  output logic [N-1:0] iss_opb,
  output logic         iss_cin,
  output logic         iss_err,
  output logic         busy
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("alu_operand_collector: TIMEOUT must be at least 1");
  end

  coll_state_e  state;
  logic         h_mode;
  logic [M-1:0] h_cmd;
  logic         h_cin;
  logic [N-1:0] h_opa;
  logic [N-1:0] h_opb;
  logic         h_miss_a;
  logic         tmr_expired;

  logic         legal_c;
  logic [1:0]   need_c;
  logic         issue_c;
  logic         err_c;
  logic         latch_c;
  logic         mode_n_c;
  logic [M-1:0] cmd_n_c;
  logic         cin_n_c;
  logic [N-1:0] opa_n_c;
  logic [N-1:0] opb_n_c;

`ifdef ALU_COLLECT_TIMEOUT_EN
  logic tmr_clear_c;
  logic tmr_enable_c;

  assign tmr_clear_c  = ce && (state == ST_IDLE);
  assign tmr_enable_c = ce && (state == ST_WAIT);

  alu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_c),
    .enable  (tmr_enable_c),
    .expired (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  // Decide this edge's action and the payload it would issue.
  always_comb begin
    legal_c  = cmd_legal(mode, 32'(cmd));
    need_c   = operand_need(mode, 4'(cmd));
    issue_c  = 1'b0;
    err_c    = 1'b0;
    latch_c  = 1'b0;
    mode_n_c = mode;
    cmd_n_c  = cmd;
    cin_n_c  = cin;
    opa_n_c  = opa;
    opb_n_c  = opb;
    case (state)
      ST_IDLE: begin
        if (!legal_c || inp_valid == 2'b00) begin
          issue_c = 1'b1;
          err_c   = 1'b1;
        end else if ((need_c & ~inp_valid) == 2'b00) begin
          issue_c = 1'b1;
        end else begin
          latch_c = 1'b1;
        end
      end
      ST_WAIT: begin
        mode_n_c = h_mode;
        cmd_n_c  = h_cmd;
        cin_n_c  = h_cin;
        opa_n_c  = h_opa;
        opb_n_c  = h_opb;
        if (h_miss_a ? inp_valid[0] : inp_valid[1]) begin
          issue_c = 1'b1;
          if (h_miss_a) opa_n_c = opa;
          else          opb_n_c = opb;
        end else if (tmr_expired) begin
          issue_c = 1'b1;
          err_c   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, held operation and registered issue port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      h_mode    <= 1'b0;
      h_cmd     <= '0;
      h_cin     <= 1'b0;
      h_opa     <= '0;
      h_opb     <= '0;
      h_miss_a  <= 1'b0;
      iss_valid <= 1'b0;
      iss_err   <= 1'b0;
      iss_mode  <= 1'b0;
      iss_cmd   <= '0;
      iss_cin   <= 1'b0;
      iss_opa   <= '0;
      iss_opb   <= '0;
    end else begin
      iss_valid <= 1'b0;
      if (ce) begin
        if (issue_c) begin
          iss_valid <= 1'b1;
          iss_err   <= err_c;
          iss_mode  <= mode_n_c;
          iss_cmd   <= cmd_n_c;
          iss_cin   <= cin_n_c;
          iss_opa   <= opa_n_c;
          iss_opb   <= opb_n_c;
          state     <= ST_IDLE;
          busy      <= 1'b0;
        end else if (latch_c) begin
          h_mode   <= mode;
          h_cmd    <= cmd;
          h_cin    <= cin;
          h_opa    <= inp_valid[0] ? opa : '0;
          h_opb    <= inp_valid[1] ? opb : '0;
          h_miss_a <= ~inp_valid[0];
          state    <= ST_WAIT;
          busy     <= 1'b1;
        end
      end
    end
  end

endmodule
